mem_ctrl: RTL

- Clocked, parametrised successor to the asynchronous en/rw/MFC memory model.
- Real DEPTH-word storage array with a programmable wait-state count.
- Same request/MFC-complete handshake toward the microcontroller control unit; adds an address-range error flag.
- Sits between the CPU control FSM (MAR/MDR side) and memory; serves instruction fetch, LOAD and STORE.

---
 rtl/mem_ctrl_pkg.sv | 42 ++++
 rtl/mem_ctrl_if.sv | 24 ++
 rtl/mem_ctrl_array.sv | 31 +++
 rtl/mem_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the clocked memory controller.
// The boot image is only consulted when MEM_CTRL_BOOT_ROM_EN is defined.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_e;

    // Which register currently drives dout; lets dout hold across writes.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_RAM,
        SRC_BOOT
    } dout_src_e;

    // Opcode field of a 16-bit program word, shared with the decoder.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int BOOT_WORDS = 8;
    localparam int BOOT_IDX_W = $clog2(BOOT_WORDS);

    localparam logic [15:0] BOOT_IMAGE [BOOT_WORDS] = '{
        16'h1010,   // LOAD  0x010
        16'h3011,   // ADD   0x011
        16'h2012,   // STORE 0x012
        16'h1013,   // LOAD  0x013
        16'h3014,   // ADD   0x014
        16'h2015,   // STORE 0x015
        16'h4000,   // JMP   0x000
        16'hF000    // HALT
    };

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request/MFC bus between the control FSM (master) and mem_ctrl (slave).
interface mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              en;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              mfc;
    logic              busy;
    logic              err;

    modport master (
        output en, rw, addr, din,
        input  dout, mfc, busy, err
    );

    modport slave (
        input  en, rw, addr, din,
        output dout, mfc, busy, err
    );
endinterface

// File: rtl/mem_ctrl_array.sv
// Single-port synchronous storage: one write port, one registered read port.
module mem_ctrl_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto RAM macros; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/mem_ctrl.sv
// Clocked memory controller: en-edge request, wait states, MFC handshake, range error.
// Optional boot ROM over words 0..7 is enabled by defining MEM_CTRL_BOOT_ROM_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_ctrl_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e            state;
    dout_src_e         dout_sel;
    logic              en_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [WCNT_W-1:0] wcnt;
    logic              mfc_q;
    logic              busy_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata;
    logic              in_range;
    logic              boot_hit;
    logic              ram_access;

    assign in_range   = 64'(addr_q) < 64'(DEPTH);
    assign ram_access = (state == ACCESS) && in_range && !boot_hit;

`ifdef MEM_CTRL_BOOT_ROM_EN
    logic [DATA_W-1:0] boot_q;

    assign boot_hit = 64'(addr_q) < 64'(BOOT_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_q <= '0;
        end else if (state == ACCESS && rw_q && in_range && boot_hit) begin
            boot_q <= DATA_W'(BOOT_IMAGE[addr_q[BOOT_IDX_W-1:0]]);
        end
    end
`else
    assign boot_hit = 1'b0;
`endif

    // NOTE: every state register uses <= so all updates see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dout_sel <= SRC_ZERO;
            en_q     <= 1'b1;
            rw_q     <= 1'b1;
            addr_q   <= '0;
            din_q    <= '0;
            wcnt     <= '0;
            mfc_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            en_q <= bus.en;
            case (state)
                IDLE: begin
                    if (bus.en && !en_q) begin
                        rw_q   <= bus.rw;
                        addr_q <= bus.addr;
                        din_q  <= bus.din;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                        wcnt   <= '0;
                        state  <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt == WCNT_LAST) begin
                        wcnt  <= '0;
                        state <= ACCESS;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ACCESS: begin
                    mfc_q <= 1'b1;
                    state <= DONE;
                    if (!in_range || (boot_hit && !rw_q)) begin
                        err_q <= 1'b1;
                    end
                    if (rw_q) begin
                        if (!in_range)     dout_sel <= SRC_ZERO;
                        else if (boot_hit) dout_sel <= SRC_BOOT;
                        else               dout_sel <= SRC_RAM;
                    end
                end
                DONE: begin
                    if (!bus.en) begin
                        mfc_q  <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_ctrl_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (ram_access && !rw_q),
        .re   (ram_access && rw_q),
        .idx  (addr_q[IDX_W-1:0]),
        .wdata(din_q),
        .rdata(rdata)
    );

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        bus.dout = '0;
        case (dout_sel)
            SRC_RAM:  bus.dout = rdata;
`ifdef MEM_CTRL_BOOT_ROM_EN
            SRC_BOOT: bus.dout = boot_q;
`endif
            default:  bus.dout = '0;
        endcase
    end

    assign bus.mfc  = mfc_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
endmodule
